// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fifo_if : byte handshake, baud enable and status for TX FIFO  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_tx_fifo_if;
    logic       baud_x1;
    logic [7:0] data;
    logic       data_strobe;
    logic       serial;
    logic       busy;
    logic       full;
    logic       empty;
    logic       overflow;

    modport master (
        output baud_x1, data, data_strobe,
        input  serial, busy, full, empty, overflow
    );

    modport slave (
        input  baud_x1, data, data_strobe,
        output serial, busy, full, empty, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fifo : FIFO-buffered UART transmitter, LSB first, 8N1 frames  |
// | Optional even parity bit when UART_TX_PARITY_EN is defined.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int STOP_BITS  = 1
) (
    input wire            mclk,
    input wire            reset,
    uart_tx_fifo_if.slave bus
);
    localparam int                  c_DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic                c_STOP_LAST = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_busy;
    logic                  r_overflow;

    state_t                r_state;
    logic                  r_serial;
    logic [7:0]            r_shift;
    logic [2:0]            r_bit_idx;
    logic                  r_stop_cnt;

    state_t                w_state_nxt;
    logic                  w_serial_nxt;
    logic [7:0]            w_shift_nxt;
    logic [2:0]            w_bit_idx_nxt;
    logic                  w_stop_cnt_nxt;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_push = bus.data_strobe && ((r_count != c_DEPTH_CNT) || w_pop);
    assign w_drop = bus.data_strobe && !w_push;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (DEPTH_LOG2 + 1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - (DEPTH_LOG2 + 1)'(1);
        end
    end

    // The shift register rotates rather than shifts, so its XOR still equals
    // the parity of the original byte once the data bits have gone out.
    always_comb begin
        w_state_nxt    = r_state;
        w_serial_nxt   = r_serial;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        w_pop          = 1'b0;
        if (bus.baud_x1) begin
            case (r_state)
                S_IDLE: begin
                    w_serial_nxt = 1'b1;
                    if (!r_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = r_mem[r_rd_ptr];
                        w_serial_nxt = 1'b0;
                        w_state_nxt  = S_START;
                    end
                end
                S_START: begin
                    w_serial_nxt  = r_shift[0];
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = S_DATA;
                end
                S_DATA: begin
                    if (r_bit_idx != 3'd7) begin
                        w_shift_nxt   = {r_shift[0], r_shift[7:1]};
                        w_serial_nxt  = r_shift[1];
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        w_serial_nxt   = ^r_shift;
                        w_state_nxt    = S_PARITY;
`else
                        w_serial_nxt   = 1'b1;
                        w_stop_cnt_nxt = 1'b0;
                        w_state_nxt    = S_STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    w_serial_nxt   = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = S_STOP;
                end
`endif
                S_STOP: begin
                    if (r_stop_cnt == c_STOP_LAST) begin
                        if (!r_empty) begin
                            w_pop        = 1'b1;
                            w_shift_nxt  = r_mem[r_rd_ptr];
                            w_serial_nxt = 1'b0;
                            w_state_nxt  = S_START;
                        end else begin
                            w_serial_nxt = 1'b1;
                            w_state_nxt  = S_IDLE;
                        end
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
                default: begin
                    w_serial_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_serial   <= 1'b1;
            r_shift    <= 8'd0;
            r_bit_idx  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_serial   <= w_serial_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt == '0);
            r_full     <= (w_count_nxt == c_DEPTH_CNT);
            r_busy     <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            r_overflow <= r_overflow | w_drop;
        end
    end

    always_ff @(posedge mclk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= bus.data;
        end
    end

    assign bus.serial   = r_serial;
    assign bus.busy     = r_busy;
    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
    localparam int c_FRAME_BITS = 11;
`else
    localparam int c_FRAME_BITS = 10;
`endif

    logic mclk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   bcnt;
    bit   ticks_on;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .DEPTH_LOG2 (4),
        .STOP_BITS  (1)
    ) dut (
        .mclk  (mclk),
        .reset (reset_n),
        .bus   (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #500us;
        $display("FAIL watchdog: observed no end of test, required finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One mclk edge, then settle and set up baud_x1 for the following edge.
    task automatic clk_step();
        @(posedge mclk);
        #1;
        if (ticks_on) begin
            bcnt = (bcnt == 15) ? 0 : bcnt + 1;
            bus.baud_x1 = (bcnt == 15);
        end else begin
            bus.baud_x1 = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.data        = b;
        bus.data_strobe = 1'b1;
        clk_step();
        bus.data_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clk_step();
        clk_step();
        reset_n = 1'b1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Waits for a start bit, then checks every bit level is held 16 cycles.
    task automatic expect_frame(input logic [7:0] b, input string tag,
                                output int waited, output logic empty_at_start);
        logic [15:0] samples;
        waited = 0;
        while (bus.serial !== 1'b0 && waited < 400) begin
            clk_step();
            waited++;
        end
        check({tag, " start"}, {31'd0, bus.serial}, 32'd0);
        empty_at_start = bus.empty;
        for (int k = 0; k < c_FRAME_BITS; k++) begin
            for (int j = 0; j < 16; j++) begin
                samples[j] = bus.serial;
                clk_step();
            end
            check($sformatf("%s bit%0d", tag, k), {16'd0, samples},
                  frame_bit(b, k) ? 32'h0000_FFFF : 32'h0);
        end
    endtask

    initial begin
        int   w;
        logic e;
        int   lows;
        n_cmp = 0;
        n_err = 0;
        bcnt = 0;
        ticks_on = 1'b0;
        reset_n = 1'b0;
        bus.baud_x1 = 1'b0;
        bus.data = 8'd0;
        bus.data_strobe = 1'b0;

        // Reset state
        do_reset();
        check("rst serial", {31'd0, bus.serial}, 32'd1);
        check("rst empty", {31'd0, bus.empty}, 32'd1);
        check("rst full", {31'd0, bus.full}, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst overflow", {31'd0, bus.overflow}, 32'd0);

        // Single byte, strobed on a tick edge: it must wait for the next tick
        ticks_on = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 40 && bus.baud_x1 !== 1'b1; i++) clk_step();
        push(8'h55);
        check("lat serial", {31'd0, bus.serial}, 32'd1);
        check("lat empty", {31'd0, bus.empty}, 32'd0);
        check("lat busy", {31'd0, bus.busy}, 32'd1);
        expect_frame(8'h55, "b55", w, e);
        check("b55 latency", w, 32'd16);
        check("b55 busy end", {31'd0, bus.busy}, 32'd0);
        check("b55 empty end", {31'd0, bus.empty}, 32'd1);

        // Back-to-back frames without idle gaps
        push(8'hA5);
        push(8'h3C);
        push(8'hFF);
        expect_frame(8'hA5, "bA5", w, e);
        expect_frame(8'h3C, "b3C", w, e);
        check("b3C gap", w, 32'd0);
        check("b3C empty", {31'd0, e}, 32'd0);
        expect_frame(8'hFF, "bFF", w, e);
        check("bFF gap", w, 32'd0);
        check("bFF empty", {31'd0, e}, 32'd1);
        check("b2b busy end", {31'd0, bus.busy}, 32'd0);

        // Overflow with ticks stopped
        ticks_on = 1'b0;
        bus.baud_x1 = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("ovf full16", {31'd0, bus.full}, 32'd1);
        check("ovf flag16", {31'd0, bus.overflow}, 32'd0);
        push(8'h10);
        check("ovf flag17", {31'd0, bus.overflow}, 32'd1);
        check("ovf full17", {31'd0, bus.full}, 32'd1);
        ticks_on = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 16; i++) begin
            expect_frame(8'(i), $sformatf("ovf%0d", i), w, e);
            if (i > 0) check($sformatf("ovf%0d gap", i), w, 32'd0);
        end
        check("ovf sticky", {31'd0, bus.overflow}, 32'd1);
        check("ovf empty end", {31'd0, bus.empty}, 32'd1);
        check("ovf busy end", {31'd0, bus.busy}, 32'd0);

        // Full FIFO, push coincides with the pop on the final stop tick
        do_reset();
        check("pp overflow clr", {31'd0, bus.overflow}, 32'd0);
        push(8'hA0);
        w = 0;
        while (bus.serial !== 1'b0 && w < 400) begin
            clk_step();
            w++;
        end
        check("pp first start", {31'd0, bus.serial}, 32'd0);
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        check("pp full", {31'd0, bus.full}, 32'd1);
        for (int i = 0; i < 143; i++) clk_step();
        push(8'h77);
        check("pp full kept", {31'd0, bus.full}, 32'd1);
        check("pp overflow", {31'd0, bus.overflow}, 32'd0);
        check("pp next start", {31'd0, bus.serial}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            expect_frame(8'h80 + 8'(i), $sformatf("pp%0d", i), w, e);
            check($sformatf("pp%0d gap", i), w, 32'd0);
        end
        expect_frame(8'h77, "pp77", w, e);
        check("pp77 gap", w, 32'd0);
        check("pp busy end", {31'd0, bus.busy}, 32'd0);

        // Reset during data bit 3 of 0xF0 with another byte queued
        push(8'hF0);
        push(8'h11);
        w = 0;
        while (bus.serial !== 1'b0 && w < 400) begin
            clk_step();
            w++;
        end
        for (int i = 0; i < 72; i++) clk_step();
        check("mid d3 level", {31'd0, bus.serial}, 32'd0);
        reset_n = 1'b0;
        clk_step();
        check("mid rst serial", {31'd0, bus.serial}, 32'd1);
        check("mid rst empty", {31'd0, bus.empty}, 32'd1);
        check("mid rst busy", {31'd0, bus.busy}, 32'd0);
        check("mid rst overflow", {31'd0, bus.overflow}, 32'd0);
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 320; i++) begin
            clk_step();
            if (bus.serial !== 1'b1) lows++;
        end
        check("post rst lows", lows, 32'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 carries a 1, 0x03 carries a 0
        push(8'h07);
        push(8'h03);
        expect_frame(8'h07, "par07", w, e);
        expect_frame(8'h03, "par03", w, e);
        check("par03 gap", w, 32'd0);
        check("par busy end", {31'd0, bus.busy}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter for the 3 Mb/s FTDI link, and the transmit-side counterpart to uart_rx.
- Accepts bytes on the same data/data_strobe handshake that uart_rx produces, so it can be fed directly by uart_rx or by any internal byte source.
- Queues bytes in a FIFO and serialises them on baud_x1 ticks (divide_by_n of clk_48, N=16).
- Absorbs bursts that arrive faster than the line rate and reports overflow instead of corrupting frames.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes (16). Legal range 1..8.
- STOP_BITS, 1: stop-bit length in bit periods. Legal values 1 or 2.

Ports:
- mclk  input  1  system clock (48 MHz); every register is clocked on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of mclk.
- baud_x1  input  1  one-mclk-cycle enable pulse per bit period.
- data  input  8  byte to enqueue.
- data_strobe  input  1  one-cycle write strobe; data is valid in the same cycle.
- serial  output  1  UART line. Idles high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- full  output  1  FIFO count == 2**DEPTH_LOG2.
- empty  output  1  FIFO count == 0.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset low at an mclk edge):
  - serial=1, state=IDLE, FIFO pointers and count=0.
  - empty=1, full=0, busy=0, overflow=0.
  - Takes effect at that same edge even mid-frame; the partial frame is abandoned with the line high, never with a glitch low.
- FIFO write:
  - On data_strobe, the byte is written if count<depth, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, overflow is set, and the FIFO contents are unchanged.
  - Simultaneous push and pop leaves count unchanged.
- Output timing:
  - Pointers wrap modulo depth.
  - full, empty and busy are registered and reflect count after the current edge.
- FSM: states IDLE, START, DATA, STOP. All transitions and serial updates happen only on mclk edges where baud_x1=1. Between ticks, state and serial hold.
  - IDLE: if FIFO is non-empty at a tick, pop the head into an 8-bit shift register, drive serial<=0, go to START. Otherwise serial stays 1.
  - START: at the next tick, serial<=shift[0], bit_idx<=0, go to DATA.
  - DATA: at each tick, if bit_idx<7, shift right and serial<=next bit, bit_idx++. If bit_idx==7, serial<=1, stop_cnt<=0, go to STOP. Data is sent LSB first.
  - STOP: at each tick, if stop_cnt==STOP_BITS-1:
    - if FIFO is non-empty, pop, serial<=0, go to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE with serial=1.
  - STOP otherwise: stop_cnt++.
- Frame length: exactly 10 bit periods with STOP_BITS=1.
- Latency: a byte strobed into an empty FIFO while IDLE starts its start bit at the first baud_x1 tick strictly after the strobe cycle.
- busy = (state!=IDLE) || !empty.
- A baud_x1 tick coinciding with data_strobe on an empty FIFO does not pop that byte in that cycle.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: an even-parity bit (XOR of the 8 data bits) is sent in a PARITY state between DATA bit 7 and STOP. Frame = 11 bit periods at STOP_BITS=1.
- When undefined: no PARITY state exists and the frame is 8N1 as above.

Test Plan:
- Single byte: reset low for 2 cycles, then release; strobe data=0x55 with baud_x1 every 16 cycles -> serial shows 0, then 1,0,1,0,1,0,1,0, then 1, each level held 16 mclk cycles; busy falls after the stop bit; a uart_rx loopback receives 0x55.
- Back-to-back: strobe 0xA5, 0x3C, 0xFF on consecutive cycles -> three contiguous 10-bit frames with no idle bits between them; empty=1 after the third pop; busy=0 after the third stop bit.
- Overflow: with no baud ticks, strobe 17 bytes 0x00..0x10 (depth 16) -> full=1 after the 16th; 17th is dropped and overflow=1; with ticks resumed, bytes 0x00..0x0F transmit in order and overflow stays 1.
- Full with simultaneous push/pop: FIFO full, STOP final tick coincides with a strobe of 0x77 -> write accepted, count stays 16, overflow=0, 0x77 is transmitted last.
- Reset mid-frame: assert reset during bit 3 of 0xF0 -> serial=1 at the next edge; FIFO empty; busy=0; overflow=0; no further low levels on serial.
- Parity (UART_TX_PARITY_EN): send 0x07 -> parity bit=1; send 0x03 -> parity bit=0; each frame is 11 bit periods.
